// File: rtl/pokey_pot_scanner.sv
// pokey_pot_scanner: N-channel paddle/potentiometer scanner for POKEY.
// One shared line counter (ticking per scanline, or per o2 cycle in fast
// mode) and per-channel capture registers. A POTGO strobe dumps the pot
// capacitors for DUMP_CYCLES cycles, then scans until every channel has
// crossed threshold or the counter reaches MAX_COUNT.
// Optional: define POKEY_POT_SYNC_EN to add a 2-flop synchronizer per pot_in bit.
module pokey_pot_scanner #(
   parameter int NUM_POTS    = 8,
   parameter int CNT_W       = 8,
   parameter int MAX_COUNT   = 228,
   parameter int LINE_DIV    = 114,
   parameter int DUMP_CYCLES = 2
) (
   input  logic                      o2,
   input  logic                      rst,
   input  logic                      potgo,
   input  logic                      fast_scan,
   input  logic [NUM_POTS-1:0]       pot_in,
   output logic [NUM_POTS-1:0]       pot_dump,
   output logic [NUM_POTS*CNT_W-1:0] pot_val,
   output logic [NUM_POTS-1:0]       allpot,
   output logic                      scan_busy,
   output logic                      scan_done
);

   localparam int PRE_W = (LINE_DIV > 1) ? $clog2(LINE_DIV) : 1;
   localparam int DT_W  = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;

   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(LINE_DIV - 1);
   localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DUMP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DUMP,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                    state,    state_n;
   logic [DT_W-1:0]           dump_tmr, dump_tmr_n;
   logic [CNT_W-1:0]          cnt,      cnt_n;
   logic [PRE_W-1:0]          pre,      pre_n;
   logic                      mode,     mode_n;
   logic [NUM_POTS-1:0]       allpot_q, allpot_n;
   logic [NUM_POTS*CNT_W-1:0] val_q,    val_n;
   logic [NUM_POTS-1:0]       pot_eff;
   logic                      tick;

`ifdef POKEY_POT_SYNC_EN
   logic [NUM_POTS-1:0] sync_q1, sync_q2;

   // Two-flop synchronizer on the threshold comparator inputs
   always_ff @(posedge o2) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= pot_in;
         sync_q2 <= sync_q1;
      end
   end

   // Scan logic sees the synchronized comparator outputs
   always_comb begin
      pot_eff = sync_q2;
   end
`else
   // Comparator outputs are already synchronous to o2
   always_comb begin
      pot_eff = pot_in;
   end
`endif

   // State and datapath registers
   always_ff @(posedge o2) begin
      if (rst) begin
         state    <= S_IDLE;
         dump_tmr <= '0;
         cnt      <= '0;
         pre      <= '0;
         mode     <= 1'b0;
         allpot_q <= '0;
         val_q    <= '0;
      end else begin
         state    <= state_n;
         dump_tmr <= dump_tmr_n;
         cnt      <= cnt_n;
         pre      <= pre_n;
         mode     <= mode_n;
         allpot_q <= allpot_n;
         val_q    <= val_n;
      end
   end

   // Next-state: potgo restarts from any state; SCAN captures, ticks and terminates
   always_comb begin
      state_n    = state;
      dump_tmr_n = dump_tmr;
      cnt_n      = cnt;
      pre_n      = pre;
      mode_n     = mode;
      allpot_n   = allpot_q;
      val_n      = val_q;
      tick       = 1'b0;

      if (potgo) begin
         state_n    = S_DUMP;
         dump_tmr_n = '0;
         cnt_n      = '0;
         pre_n      = '0;
         allpot_n   = '1;
         mode_n     = fast_scan;
      end else begin
         case (state)
            S_IDLE: begin
               state_n = S_IDLE;
            end
            S_DUMP: begin
               if (dump_tmr == DT_LAST) begin
                  state_n = S_SCAN;
                  cnt_n   = '0;
                  pre_n   = '0;
               end else begin
                  dump_tmr_n = dump_tmr + DT_W'(1);
               end
            end
            S_SCAN: begin
               tick  = mode || (pre == PRE_LAST);
               pre_n = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
               for (int unsigned i = 0; i < NUM_POTS; i++) begin
                  if (allpot_q[i] && pot_eff[i]) begin
                     val_n[i*CNT_W +: CNT_W] = cnt;
                     allpot_n[i]             = 1'b0;
                  end
               end
               // Terminal tick: same-cycle captures already hold MAX_C since cnt == MAX_C
               if (tick) begin
                  if (cnt == MAX_C) begin
                     for (int unsigned i = 0; i < NUM_POTS; i++) begin
                        if (allpot_n[i]) begin
                           val_n[i*CNT_W +: CNT_W] = MAX_C;
                        end
                     end
                     allpot_n = '0;
                  end else begin
                     cnt_n = cnt + CNT_W'(1);
                  end
               end
               if (allpot_n == '0) begin
                  state_n = S_DONE;
               end
            end
            S_DONE: begin
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from state; a restart strobe masks the completion pulse
   always_comb begin
      pot_dump  = (state == S_SCAN) ? '0 : '1;
      scan_busy = (state == S_DUMP) || (state == S_SCAN);
      scan_done = (state == S_DONE) && !potgo;
      allpot    = allpot_q;
      pot_val   = val_q;
   end

endmodule
